// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA/SVGA raster timing generator. A pair of free-running
// counters walks the raster. Display enable and both syncs are decoded from
// those counters into a registered "stage 0". A CE-qualified delay line then
// re-times them so they line up with a downstream pixel pipeline of known
// latency. Line, frame and vertical-blank strobes are decoded directly from the
// current counter values. They are not delayed, so fetch logic gets them as
// early as possible.
//
// Ports
//   PIXEL_CLOCK  in   1     pixel clock, all logic on the rising edge
//   RESET_N      in   1     asynchronous active-low reset
//   CE           in   1     count enable; counters and delay line advance on 1
//   X            out  X_W   horizontal count, 0 .. H_TOTAL-1
//   Y            out  Y_W   vertical count,   0 .. V_TOTAL-1
//   DE           out  1     display enable, latency 1+PIPE_DELAY enabled cycles
//   HS           out  1     horizontal sync (H_POL when active), same latency
//   VS           out  1     vertical sync (V_POL when active), same latency
//   LINE_START   out  1     X==0 while CE=1
//   FRAME_START  out  1     X==0 and Y==0 while CE=1
//   VBLANK_IRQ   out  1     X==0 and Y==V_ACTIVE while CE=1
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter int H_POL      = 1,
    parameter int V_POL      = 1,
    parameter int X_W        = 11,
    parameter int Y_W        = 10,
    parameter int PIPE_DELAY = 2
) (
    input  logic           PIXEL_CLOCK,
    input  logic           RESET_N,
    input  logic           CE,
    output logic [X_W-1:0] X,
    output logic [Y_W-1:0] Y,
    output logic           DE,
    output logic           HS,
    output logic           VS,
    output logic           LINE_START,
    output logic           FRAME_START,
    output logic           VBLANK_IRQ
);

    // -------------------------------------------------------------------------
    // Derived geometry
    // -------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // -------------------------------------------------------------------------
    // Elaboration-time sanity checks. Widths are capped at 30 bits so that
    // the capacity expression below stays within a positive int.
    // -------------------------------------------------------------------------
    generate
        if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_active
            $fatal(1, "vga_timing_gen: active area must be at least 1x1");
        end
        if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_bad_h_porch
            $fatal(1, "vga_timing_gen: horizontal porch/sync widths must be >= 1");
        end
        if (V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_v_porch
            $fatal(1, "vga_timing_gen: vertical porch/sync widths must be >= 1");
        end
        if (X_W < 1 || X_W > 30 || (H_TOTAL - 1) >= (1 << X_W)) begin : g_bad_x_w
            $fatal(1, "vga_timing_gen: X_W too narrow for H_TOTAL-1");
        end
        if (Y_W < 1 || Y_W > 30 || (V_TOTAL - 1) >= (1 << Y_W)) begin : g_bad_y_w
            $fatal(1, "vga_timing_gen: Y_W too narrow for V_TOTAL-1");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_bad_pipe
            $fatal(1, "vga_timing_gen: PIPE_DELAY must be in 0..8");
        end
    endgenerate

    // Counter-width copies of the decode boundaries. The porches are all at
    // least one wide, so every boundary is <= TOTAL-1 and fits the counter.
    localparam logic [X_W-1:0] X_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] X_ACT_END  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] X_HS_START = X_W'(H_ACTIVE + H_FRONT);
    localparam logic [X_W-1:0] X_HS_END   = X_W'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_ACT_END  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] Y_VS_START = Y_W'(V_ACTIVE + V_FRONT);
    localparam logic [Y_W-1:0] Y_VS_END   = Y_W'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic HS_ACT = (H_POL != 0);
    localparam logic VS_ACT = (V_POL != 0);

    // -------------------------------------------------------------------------
    // Raster counters
    // -------------------------------------------------------------------------
    logic [X_W-1:0] x_reg;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_reg;
    logic [Y_W-1:0] y_next;

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (CE) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                // The last pixel of the last line wraps straight to (0,0),
                // with no dead cycle in between.
                y_next = (y_reg == Y_LAST) ? '0 : y_reg + Y_W'(1);
            end else begin
                x_next = x_reg + X_W'(1);
            end
        end
    end

    always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 0 decode from the pre-increment counter values
    // -------------------------------------------------------------------------
    logic de_s0_next;
    logic hs_s0_next;
    logic vs_s0_next;

    always_comb begin
        de_s0_next = (x_reg < X_ACT_END) && (y_reg < Y_ACT_END);
        hs_s0_next = ~HS_ACT;
        vs_s0_next = ~VS_ACT;
        if ((x_reg >= X_HS_START) && (x_reg < X_HS_END)) begin
            hs_s0_next = HS_ACT;
        end
        // VS depends only on Y, so it can only change at a line boundary.
        if ((y_reg >= Y_VS_START) && (y_reg < Y_VS_END)) begin
            vs_s0_next = VS_ACT;
        end
    end

    // Index 0 is stage 0. Index PIPE_DELAY drives the outputs, so with
    // PIPE_DELAY=0 the outputs come straight from stage 0.
    logic de_pipe_reg [0:PIPE_DELAY];
    logic hs_pipe_reg [0:PIPE_DELAY];
    logic vs_pipe_reg [0:PIPE_DELAY];

    always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            de_pipe_reg[0] <= 1'b0;
            hs_pipe_reg[0] <= ~HS_ACT;
            vs_pipe_reg[0] <= ~VS_ACT;
        end else if (CE) begin
            de_pipe_reg[0] <= de_s0_next;
            hs_pipe_reg[0] <= hs_s0_next;
            vs_pipe_reg[0] <= vs_s0_next;
        end
    end

    // Delay line. Each stage advances only on CE, so the alignment to the
    // counters is counted in enabled cycles, not raw clocks.
    generate
        for (genvar gi = 1; gi <= PIPE_DELAY; gi++) begin : g_pipe
            always_ff @(posedge PIXEL_CLOCK or negedge RESET_N) begin
                if (!RESET_N) begin
                    de_pipe_reg[gi] <= 1'b0;
                    hs_pipe_reg[gi] <= ~HS_ACT;
                    vs_pipe_reg[gi] <= ~VS_ACT;
                end else if (CE) begin
                    de_pipe_reg[gi] <= de_pipe_reg[gi-1];
                    hs_pipe_reg[gi] <= hs_pipe_reg[gi-1];
                    vs_pipe_reg[gi] <= vs_pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic x_at_zero;
    logic strobe_ok;

    assign x_at_zero = (x_reg == '0);
    // The counters sit at (0,0) during reset. Gating with RESET_N keeps the
    // strobes quiet until the first enabled cycle after release.
    assign strobe_ok = RESET_N && CE && x_at_zero;

    assign X           = x_reg;
    assign Y           = y_reg;
    assign DE          = de_pipe_reg[PIPE_DELAY];
    assign HS          = hs_pipe_reg[PIPE_DELAY];
    assign VS          = vs_pipe_reg[PIPE_DELAY];
    assign LINE_START  = strobe_ok;
    assign FRAME_START = strobe_ok && (y_reg == '0);
    assign VBLANK_IRQ  = strobe_ok && (y_reg == Y_ACT_END);

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Four generators share clock, reset and CE:
//   u_a  small geometry (H 8/2/2/2, V 4/1/1/1), PIPE_DELAY=0, active-high syncs
//   u_b  same geometry, PIPE_DELAY=3
//   u_c  same geometry, PIPE_DELAY=0, active-low syncs
//   u_d  default 800x600 geometry
// Small geometry: H_TOTAL=14, V_TOTAL=7, 98 clocks per frame.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic ce;

    logic [3:0]  a_x, b_x, c_x;
    logic [2:0]  a_y, b_y, c_y;
    logic        a_de, a_hs, a_vs, a_line, a_frame, a_vbl;
    logic        b_de, b_hs, b_vs, b_line, b_frame, b_vbl;
    logic        c_de, c_hs, c_vs, c_line, c_frame, c_vbl;
    logic [10:0] d_x;
    logic [9:0]  d_y;
    logic        d_de, d_hs, d_vs, d_line, d_frame, d_vbl;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(1), .V_POL(1), .X_W(4), .Y_W(3), .PIPE_DELAY(0)
    ) u_a (
        .PIXEL_CLOCK(clk), .RESET_N(rst_n), .CE(ce), .X(a_x), .Y(a_y),
        .DE(a_de), .HS(a_hs), .VS(a_vs), .LINE_START(a_line),
        .FRAME_START(a_frame), .VBLANK_IRQ(a_vbl)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(1), .V_POL(1), .X_W(4), .Y_W(3), .PIPE_DELAY(3)
    ) u_b (
        .PIXEL_CLOCK(clk), .RESET_N(rst_n), .CE(ce), .X(b_x), .Y(b_y),
        .DE(b_de), .HS(b_hs), .VS(b_vs), .LINE_START(b_line),
        .FRAME_START(b_frame), .VBLANK_IRQ(b_vbl)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(0), .V_POL(0), .X_W(4), .Y_W(3), .PIPE_DELAY(0)
    ) u_c (
        .PIXEL_CLOCK(clk), .RESET_N(rst_n), .CE(ce), .X(c_x), .Y(c_y),
        .DE(c_de), .HS(c_hs), .VS(c_vs), .LINE_START(c_line),
        .FRAME_START(c_frame), .VBLANK_IRQ(c_vbl)
    );

    vga_timing_gen u_d (
        .PIXEL_CLOCK(clk), .RESET_N(rst_n), .CE(ce), .X(d_x), .Y(d_y),
        .DE(d_de), .HS(d_hs), .VS(d_vs), .LINE_START(d_line),
        .FRAME_START(d_frame), .VBLANK_IRQ(d_vbl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Stage-0 value {de,hs,vs} for the small geometry, active-high syncs.
    function automatic logic [2:0] ref_stage(input int x, input int y);
        logic de, hs, vs;
        de = (x < 8) && (y < 4);
        hs = (x >= 10) && (x < 12);
        vs = (y == 5);
        return {de, hs, vs};
    endfunction

    // Short reset pulse, started and released between clock edges.
    task automatic restart();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int xs [0:199];
    int ys [0:199];

    initial begin
        int mism_xy, mism_a, mism_b, mism_c, mism_strb;
        int de_cnt, hs_cnt, vs_cnt, line_cnt, frame_cnt, vbl_cnt, vbl_k;
        int ce_bad, next_k;
        logic [2:0] exp_a, exp_b, exp_c;
        logic exp_line, exp_frame, exp_vbl;

        // ---------------- reset state (CE high, strobes must stay low) -------
        rst_n = 1'b0;
        ce    = 1'b1;
        #12;
        check("rst_a_x", 32'(a_x), 0);
        check("rst_a_y", 32'(a_y), 0);
        check("rst_a_de", 32'(a_de), 0);
        check("rst_a_hs", 32'(a_hs), 0);
        check("rst_a_vs", 32'(a_vs), 0);
        check("rst_b_de", 32'(b_de), 0);
        check("rst_c_hs", 32'(c_hs), 1);
        check("rst_c_vs", 32'(c_vs), 1);
        check("rst_d_hs", 32'(d_hs), 0);
        check("rst_a_line", 32'(a_line), 0);
        check("rst_a_frame", 32'(a_frame), 0);

        // ---------------- free-running stream, two small frames --------------
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_a_frame", 32'(a_frame), 1);
        check("rel_a_line", 32'(a_line), 1);
        check("rel_a_vbl", 32'(a_vbl), 0);

        mism_xy = 0; mism_a = 0; mism_b = 0; mism_c = 0; mism_strb = 0;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        line_cnt = 0; frame_cnt = 0; vbl_cnt = 0; vbl_k = -1;
        for (int k = 0; k < 196; k++) begin
            if (k > 0) tick();
            xs[k] = k % 14;
            ys[k] = (k / 14) % 7;
            exp_a = (k >= 1) ? ref_stage(xs[k-1], ys[k-1]) : 3'b000;
            exp_b = (k >= 4) ? ref_stage(xs[k-4], ys[k-4]) : 3'b000;
            exp_c = {exp_a[2], ~exp_a[1], ~exp_a[0]};
            exp_line  = (xs[k] == 0);
            exp_frame = (xs[k] == 0) && (ys[k] == 0);
            exp_vbl   = (xs[k] == 0) && (ys[k] == 4);

            if (int'(a_x) != xs[k] || int'(a_y) != ys[k]) mism_xy++;
            if (int'(b_x) != xs[k] || int'(b_y) != ys[k]) mism_xy++;
            if (int'(c_x) != xs[k] || int'(c_y) != ys[k]) mism_xy++;
            if ({a_de, a_hs, a_vs} !== exp_a) mism_a++;
            if ({b_de, b_hs, b_vs} !== exp_b) mism_b++;
            if ({c_de, c_hs, c_vs} !== exp_c) mism_c++;
            if ({a_line, a_frame, a_vbl} !== {exp_line, exp_frame, exp_vbl}) mism_strb++;
            if ({b_line, b_frame, b_vbl} !== {exp_line, exp_frame, exp_vbl}) mism_strb++;
            if ({c_line, c_frame, c_vbl} !== {exp_line, exp_frame, exp_vbl}) mism_strb++;

            if (k >= 1 && k <= 98) begin
                de_cnt += int'(a_de);
                hs_cnt += int'(a_hs);
                vs_cnt += int'(a_vs);
            end
            if (k <= 97) begin
                line_cnt  += int'(a_line);
                frame_cnt += int'(a_frame);
                vbl_cnt   += int'(a_vbl);
                if (a_vbl && vbl_k < 0) vbl_k = k;
            end

            if (k == 3)  check("b_de_before_lag", 32'(b_de), 0);
            if (k == 4)  check("b_de_after_lag", 32'(b_de), 1);
            if (k == 11) begin
                check("a_hs_from_x10", 32'(a_hs), 1);
                check("c_hs_from_x10", 32'(c_hs), 0);
                check("b_hs_from_x7", 32'(b_hs), 0);
            end
            if (k == 14) begin
                check("a_hs_from_x13", 32'(a_hs), 0);
                check("b_hs_from_x10", 32'(b_hs), 1);
            end
            if (k == 70) check("a_vs_line4", 32'(a_vs), 0);
            if (k == 71) check("a_vs_line5", 32'(a_vs), 1);
            if (k == 97) begin
                check("a_x_last", 32'(a_x), 13);
                check("a_y_last", 32'(a_y), 6);
            end
            if (k == 98) begin
                check("a_x_wrap", 32'(a_x), 0);
                check("a_y_wrap", 32'(a_y), 0);
                check("a_frame_wrap", 32'(a_frame), 1);
            end
        end
        check("frame_de_cycles", 32'(de_cnt), 32);
        check("frame_hs_cycles", 32'(hs_cnt), 14);
        check("frame_vs_cycles", 32'(vs_cnt), 14);
        check("frame_line_pulses", 32'(line_cnt), 7);
        check("frame_frame_pulses", 32'(frame_cnt), 1);
        check("frame_vbl_pulses", 32'(vbl_cnt), 1);
        check("vbl_at_x0_y4", 32'(vbl_k), 56);
        check("xy_mismatches", 32'(mism_xy), 0);
        check("a_stream_mismatches", 32'(mism_a), 0);
        check("b_stream_mismatches", 32'(mism_b), 0);
        check("c_stream_mismatches", 32'(mism_c), 0);
        check("strobe_mismatches", 32'(mism_strb), 0);

        // ---------------- asynchronous reset mid-frame at (5,3) -------------
        restart();
        for (int i = 0; i < 47; i++) tick();
        check("pre_rst_a_x", 32'(a_x), 5);
        check("pre_rst_a_y", 32'(a_y), 3);
        check("pre_rst_a_de", 32'(a_de), 1);
        check("pre_rst_b_de", 32'(b_de), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_a_x", 32'(a_x), 0);
        check("async_rst_a_y", 32'(a_y), 0);
        check("async_rst_a_de", 32'(a_de), 0);
        check("async_rst_b_de", 32'(b_de), 0);
        check("async_rst_c_hs", 32'(c_hs), 1);
        check("async_rst_c_vs", 32'(c_vs), 1);
        check("async_rst_a_frame", 32'(a_frame), 0);
        tick();
        check("held_rst_a_x", 32'(a_x), 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_frame", 32'(a_frame), 1);
        tick();
        check("post_rst_a_x", 32'(a_x), 1);
        check("post_rst_frame_gone", 32'(a_frame), 0);

        // ---------------- CE toggling 1,0,1,0 ... ---------------------------
        restart();
        line_cnt = 0; de_cnt = 0; hs_cnt = 0; ce_bad = 0;
        for (int j = 0; j < 29; j++) begin
            ce = (j % 2 == 0);
            #1;
            line_cnt += int'(a_line);
            if (!ce && (a_line || a_frame || a_vbl)) ce_bad++;
            de_cnt += int'(a_de);
            hs_cnt += int'(a_hs);
            tick();
        end
        ce = 1'b1;
        check("ce_x_half_rate", 32'(a_x), 1);
        check("ce_y_half_rate", 32'(a_y), 1);
        check("ce_line_pulses", 32'(line_cnt), 2);
        check("ce_strobe_while_off", 32'(ce_bad), 0);
        check("ce_de_doubled", 32'(de_cnt), 16);
        check("ce_hs_doubled", 32'(hs_cnt), 4);

        // ---------------- default 800x600 geometry, one line -----------------
        restart();
        #1;
        check("d_frame_first", 32'(d_frame), 1);
        next_k = 0;
        for (int k = 1; k <= 1060; k++) begin
            tick();
            if (d_line && next_k == 0) next_k = k;
            if (k == 802)  check("d_de_x799", 32'(d_de), 1);
            if (k == 803)  check("d_de_x800", 32'(d_de), 0);
            if (k == 842)  check("d_hs_x839", 32'(d_hs), 0);
            if (k == 843)  check("d_hs_x840", 32'(d_hs), 1);
            if (k == 970)  check("d_hs_x967", 32'(d_hs), 1);
            if (k == 971)  check("d_hs_x968", 32'(d_hs), 0);
            if (k == 1055) check("d_x_last", 32'(d_x), 1055);
            if (k == 1056) begin
                check("d_x_wrap", 32'(d_x), 0);
                check("d_y_next", 32'(d_y), 1);
            end
        end
        check("d_line_period", 32'(next_k), 1056);
        check("d_vs_idle", 32'(d_vs), 0);
        check("d_vbl_idle", 32'(d_vbl), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
